// File: rtl/fft_pkg.sv
// Shared types for the FFT framing controller: sample type, controller
// states and the frame-length helper used to size storage.
package fft_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] fpt;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2,
        UNLOAD = 2'd3
    } state_t;

    // Number of samples in one frame for a given log2 length.
    function automatic int frame_len(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/frame_buf.sv
// Single-frame sample store: one write port, one registered read port.
// Contents are never cleared; the controller tracks which entries are live.
module frame_buf
    import fft_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         wr_en,
    input  logic [N-1:0] wr_addr,
    input  fpt           wr_data,
    input  logic [N-1:0] rd_addr,
    output fpt           rd_data
);

    localparam int DEPTH = frame_len(N);

    fpt mem [DEPTH];

    // Write port: store an accepted sample at its frame position.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: one-cycle registered read, free-running every cycle.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame controller in front of a streaming FFT: collects 2^N samples,
// replays them gap-free with a start pulse, waits for the FFT result
// (with a timeout) and qualifies the 2^N output cycles.
`ifndef N_
`define N_ 3
`endif

module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int N       = `N_,
    parameter int LAT_MAX = 15 * (1 << N)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  fpt          in_data,
    output logic        fft_start_ip,
    output fpt          fft_ip,
    input  logic        fft_op_ready,
    output logic        out_valid,
    output logic        out_last,
    output logic [15:0] frame_cnt,
    output logic        timeout_err
);

    localparam int           WAIT_W   = $clog2(LAT_MAX + 1);
    localparam logic [N-1:0] LAST_IDX = N'(frame_len(N) - 1);

    state_t              state;
    state_t              state_next;
    logic [N-1:0]        wr_cnt;
    logic [N-1:0]        rd_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [N-1:0]        rd_addr;
    fpt                  rd_data;
    logic                wr_en;
    logic                stream_active;
    logic                timed_out;

    assign wr_en = in_valid && in_ready;

    // The WAIT cycle with wait_cnt == LAT_MAX-1 is the LAT_MAX-th one spent waiting.
    assign timed_out = (state == WAIT) && !fft_op_ready &&
                       (wait_cnt == WAIT_W'(LAT_MAX - 1));

    // The read register runs one sample ahead of fft_ip, so buf[0] is already
    // loaded on the last FILL write and buf[k+1] is fetched while buf[k] is shown.
    assign rd_addr = (state == STREAM) ? rd_cnt + N'(1) : '0;

    frame_buf #(.N(N)) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; fft_op_ready wins over the timeout in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (wr_en && wr_cnt == LAST_IDX) state_next = STREAM;
            STREAM:  if (rd_cnt == LAST_IDX)          state_next = WAIT;
            WAIT:    if (fft_op_ready)                state_next = UNLOAD;
                     else if (timed_out)              state_next = FILL;
            UNLOAD:  if (rd_cnt == LAST_IDX)          state_next = FILL;
            default:                                  state_next = FILL;
        endcase
    end

    // Outputs are masked while reset is held so nothing leaks from an aborted frame.
    always_comb begin
        in_ready      = !reset && (state == FILL);
        stream_active = !reset && (state == STREAM);
        fft_start_ip  = stream_active && (rd_cnt == '0);
        fft_ip        = stream_active ? rd_data : '0;
        out_valid     = !reset && (state == UNLOAD);
        out_last      = out_valid && (rd_cnt == LAST_IDX);
    end

    // Frame position counters; rd_cnt indexes both the replay and the unload beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            wait_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_cnt <= wr_cnt + N'(1);
            end
            if (state == STREAM || state == UNLOAD) begin
                rd_cnt <= rd_cnt + N'(1);
            end
            if (state == WAIT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Completed-frame count and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (out_last) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (timed_out) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with an 8-point frame.
module tb_fft_frame_ctrl;
    import fft_pkg::*;

    localparam int N   = 3;
    localparam int LEN = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    fpt          in_data;
    logic        fft_start_ip;
    fpt          fft_ip;
    logic        fft_op_ready;
    logic        out_valid;
    logic        out_last;
    logic [15:0] frame_cnt;
    logic        timeout_err;

    int tests = 0;
    int fails = 0;
    int start_pulses = 0;
    int valid_beats = 0;
    int s0;
    int v0;

    fft_frame_ctrl #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .fft_start_ip (fft_start_ip),
        .fft_ip       (fft_ip),
        .fft_op_ready (fft_op_ready),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .frame_cnt    (frame_cnt),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        if (fft_start_ip === 1'b1) start_pulses <= start_pulses + 1;
        if (out_valid === 1'b1)    valid_beats  <= valid_beats + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Write one frame base..base+7; with gaps, in_valid is low every other cycle.
    task automatic feed_frame(input int base, input bit gaps);
        for (int i = 0; i < LEN; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = '0;
                tick();
                check("fill_ready_gap", in_ready, 1);
                check("fill_no_start", fft_start_ip, 0);
            end
            check("fill_ready", in_ready, 1);
            in_valid = 1'b1;
            in_data  = fpt'(base + i);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Entered on the first STREAM cycle; leaves on the first WAIT cycle.
    task automatic check_stream(input int base);
        for (int k = 0; k < LEN; k++) begin
            check("stream_data", fft_ip, fpt'(base + k));
            check("stream_start", fft_start_ip, (k == 0));
            check("stream_ready", in_ready, 0);
            check("stream_no_valid", out_valid, 0);
            tick();
        end
        check("wait_ip_zero", fft_ip, 0);
        check("wait_no_start", fft_start_ip, 0);
        check("wait_ready", in_ready, 0);
    endtask

    // Entered on the first WAIT cycle; raise fft_op_ready after wait_cycles cycles.
    task automatic wait_unload(input int wait_cycles, input logic [15:0] fc);
        fft_op_ready = 1'b0;
        for (int i = 0; i < wait_cycles; i++) tick();
        check("wait_no_valid", out_valid, 0);
        check("wait_ready_low", in_ready, 0);
        fft_op_ready = 1'b1;
        tick();
        fft_op_ready = 1'b0;
        for (int j = 0; j < LEN; j++) begin
            check("unload_valid", out_valid, 1);
            check("unload_last", out_last, (j == LEN - 1));
            check("unload_fcnt", frame_cnt, fc);
            check("unload_ready", in_ready, 0);
            check("unload_ip_zero", fft_ip, 0);
            tick();
        end
        check("post_valid", out_valid, 0);
        check("post_last", out_last, 0);
        check("post_fcnt", frame_cnt, fc + 16'd1);
        check("post_ready", in_ready, 1);
    endtask

    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        fft_op_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_start", fft_start_ip, 0);
        check("rst_ip", fft_ip, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_fcnt", frame_cnt, 0);
        check("rst_err", timeout_err, 0);
        reset = 1'b0;
        #1;
        check("after_rst_ready", in_ready, 1);
        check("after_rst_start", fft_start_ip, 0);
        check("after_rst_ip", fft_ip, 0);
        check("after_rst_valid", out_valid, 0);

        // Continuous frame 0..7, FFT answers 20 cycles after the start pulse.
        feed_frame(0, 1'b0);
        check_stream(0);
        wait_unload(12, 16'd0);
        check("f1_err", timeout_err, 0);

        // Gapped input; FFT answers on the very last WAIT cycle, beating the timeout.
        feed_frame(16, 1'b1);
        check_stream(16);
        wait_unload(119, 16'd1);
        check("edge_err_clear", timeout_err, 0);

        // FFT never answers: timeout after 120 WAIT cycles.
        feed_frame(32, 1'b0);
        check_stream(32);
        fft_op_ready = 1'b0;
        repeat (119) tick();
        check("to_err_pending", timeout_err, 0);
        check("to_still_wait", in_ready, 0);
        tick();
        check("to_err_set", timeout_err, 1);
        check("to_back_fill", in_ready, 1);
        check("to_fcnt", frame_cnt, 2);
        check("to_no_valid", out_valid, 0);

        // Next frame (signed samples) runs normally, flag stays set.
        feed_frame(-4, 1'b0);
        check_stream(-4);
        wait_unload(3, 16'd2);
        check("sticky_err", timeout_err, 1);

        // Reset while streaming sample 4.
        feed_frame(90, 1'b0);
        repeat (4) tick();
        check("pre_rst_ip", fft_ip, fpt'(94));
        reset = 1'b1;
        #1;
        check("mid_rst_ip", fft_ip, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_start", fft_start_ip, 0);
        tick();
        reset = 1'b0;
        #1;
        check("abort_ip", fft_ip, 0);
        check("abort_ready", in_ready, 1);
        check("abort_fcnt", frame_cnt, 0);
        check("abort_err", timeout_err, 0);
        check("abort_valid", out_valid, 0);

        // Three back-to-back frames after the abort.
        s0 = start_pulses;
        v0 = valid_beats;
        for (int f = 0; f < 3; f++) begin
            feed_frame(100 + 8 * f, 1'b0);
            check_stream(100 + 8 * f);
            wait_unload(0, 16'(f));
        end
        check("b2b_fcnt", frame_cnt, 3);
        check("b2b_starts", start_pulses - s0, 3);
        check("b2b_valids", valid_beats - v0, 24);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
